sort_job_sched: RTL

//  Shares one sort engine (AGU/CTRL/SBU/CNTU/PRU pipeline) between REQ_NUM clients.

---
 rtl/sort_job_sched.sv | 109 ++++++++++
 1 files changed

// File: rtl/sort_job_sched.sv
// sort_job_sched: round-robin arbiter that lends one sort engine to REQ_NUM clients,
// forwarding the granted client's key stream in and steering engine outputs back.
module sort_job_sched #(
    parameter int REQ_NUM     = 4,
    parameter int DATA_W      = 8,
    parameter int OUTPORT_NUM = 1,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [REQ_NUM-1:0]             req_vld_i,
    input  logic [REQ_NUM-1:0]             req_mode_i,
    input  logic [REQ_NUM-1:0]             in_vld_i,
    input  logic [REQ_NUM*DATA_W-1:0]      in_data_i,
    input  logic [REQ_NUM-1:0]             in_done_i,
    output logic [REQ_NUM-1:0]             gnt_o,
    output logic                           busy_o,
    output logic                           sort_vld_o,
    output logic [DATA_W-1:0]              sort_data_o,
    output logic                           sort_done_vld_o,
    output logic                           sort_mode_o,
    input  logic [OUTPORT_NUM-1:0]         sort_out_vld_i,
    input  logic                           sort_out_done_i,
    output logic [REQ_NUM*OUTPORT_NUM-1:0] cli_out_vld_o,
    output logic [REQ_NUM-1:0]             cli_out_done_o,
    output logic                           timeout_o
);
    localparam int PW = $clog2(REQ_NUM);
    localparam int CW = $clog2(TIMEOUT_CYC);
    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, GAP} state_t;
    state_t              state_q;
    logic [REQ_NUM-1:0]  gnt_q;
    logic [PW-1:0]       rr_q, gidx_q, win_d, idx;
    logic [PW:0]         sum;
    logic                hit_d, mode_q, sort_vld_q, sort_done_q, timeout_q;
    logic [DATA_W-1:0]   sort_data_q;
    logic [CW-1:0]       cnt_q;
    logic                drain, out_done, expire;
    // First requester at or after rr_q, wrapping modulo REQ_NUM
    always_comb begin
        win_d = '0;
        hit_d = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            sum = {1'b0, rr_q} + (PW+1)'(i);
            idx = (sum >= (PW+1)'(REQ_NUM)) ? PW'(sum - (PW+1)'(REQ_NUM)) : PW'(sum);
            if (!hit_d && req_vld_i[idx]) begin
                hit_d = 1'b1;
                win_d = idx;
            end
        end
    end
    assign drain    = state_q == DRAIN;
    assign out_done = drain && sort_out_done_i;
    assign expire   = drain && !sort_out_done_i && cnt_q == CW'(TIMEOUT_CYC-1);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gidx_q      <= '0;
            rr_q        <= '0;
            mode_q      <= 1'b0;
            sort_vld_q  <= 1'b0;
            sort_data_q <= '0;
            sort_done_q <= 1'b0;
            timeout_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            sort_vld_q  <= state_q == LOAD && in_vld_i[gidx_q];
            sort_data_q <= state_q == LOAD ? in_data_i[gidx_q*DATA_W +: DATA_W] : '0;
            sort_done_q <= state_q == LOAD && in_done_i[gidx_q];
            timeout_q   <= expire;
            case (state_q)
                IDLE: if (hit_d) begin
                    state_q <= LOAD;
                    gnt_q   <= REQ_NUM'(1) << win_d;
                    gidx_q  <= win_d;
                    mode_q  <= req_mode_i[win_d];
                    rr_q    <= (win_d == PW'(REQ_NUM-1)) ? '0 : win_d + 1'b1;
                end
                LOAD: if (in_done_i[gidx_q]) begin
                    state_q <= DRAIN;
                    cnt_q   <= '0;
                end
                DRAIN: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (sort_out_done_i || expire) begin
                        state_q <= GAP;
                        gnt_q   <= '0;
                        mode_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign gnt_o           = gnt_q;
    assign busy_o          = state_q != IDLE;
    assign sort_vld_o      = sort_vld_q;
    assign sort_data_o     = sort_data_q;
    assign sort_done_vld_o = sort_done_q;
    assign sort_mode_o     = mode_q;
    assign timeout_o       = timeout_q;
    assign cli_out_done_o  = out_done ? gnt_q : '0;
    for (genvar k = 0; k < REQ_NUM; k++) begin : g_cli
        assign cli_out_vld_o[k*OUTPORT_NUM +: OUTPORT_NUM] = (drain && gnt_q[k]) ? sort_out_vld_i : '0;
    end
endmodule
